// File: rtl/sa_perf_monitor_if.sv
// Bus bundle for sa_perf_monitor: per-channel job events, timeout limit,
// counter read request/response and per-channel status flags.
interface sa_perf_monitor_if #(
   parameter int NUM_CH      = 4,
   parameter int NUM_CH_LOG2 = 2,
   parameter int CNT_BWIDTH  = 32
);
   logic                   CLEAR_in;
   logic [NUM_CH-1:0]      START_in;
   logic [NUM_CH-1:0]      DONE_in;
   logic [NUM_CH-1:0]      STALL_in;
   logic [CNT_BWIDTH-1:0]  TIMEOUT_in;
   logic                   RD_EN_in;
   logic [NUM_CH_LOG2-1:0] RD_CH_in;
   logic [2:0]             RD_SEL_in;
   logic                   RD_VALID_out;
   logic [CNT_BWIDTH-1:0]  RD_DATA_out;
   logic [NUM_CH-1:0]      BUSY_out;
   logic [NUM_CH-1:0]      TIMEOUT_out;
   logic [NUM_CH-1:0]      ERR_out;

   modport master (
      output CLEAR_in, START_in, DONE_in, STALL_in, TIMEOUT_in,
      output RD_EN_in, RD_CH_in, RD_SEL_in,
      input  RD_VALID_out, RD_DATA_out, BUSY_out, TIMEOUT_out, ERR_out
   );

   modport slave (
      input  CLEAR_in, START_in, DONE_in, STALL_in, TIMEOUT_in,
      input  RD_EN_in, RD_CH_in, RD_SEL_in,
      output RD_VALID_out, RD_DATA_out, BUSY_out, TIMEOUT_out, ERR_out
   );
endinterface

// File: rtl/sa_perf_monitor.sv
// Per-channel job monitor (IDLE/RUN/HALT) with saturating counters and registered readback.
// Define SA_PERF_MINMAX_EN to build per-channel MIN_LAT/MAX_LAT tracking.
module sa_perf_monitor #(
   parameter int NUM_CH      = 4,
   parameter int NUM_CH_LOG2 = 2,
   parameter int CNT_BWIDTH  = 32
) (
   input  logic             CLK,
   input  logic             RST,
   sa_perf_monitor_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;
   typedef logic [CNT_BWIDTH-1:0] cnt_t;

   state_t state_q [NUM_CH];
   state_t state_d [NUM_CH];

   cnt_t run_cnt   [NUM_CH];
   cnt_t last_lat  [NUM_CH];
   cnt_t job_cnt   [NUM_CH];
   cnt_t stall_cnt [NUM_CH];
   cnt_t busy_cnt  [NUM_CH];
`ifdef SA_PERF_MINMAX_EN
   cnt_t min_lat   [NUM_CH];
   cnt_t max_lat   [NUM_CH];
`endif

   logic [NUM_CH-1:0] start_evt, done_evt, count_evt, err_evt, to_evt, busy_vec;
   logic [NUM_CH-1:0] to_q, err_q;
   logic [NUM_CH_LOG2-1:0] rd_ch;
   logic rd_valid_q;
   cnt_t rd_data_q, rd_mux;

   function automatic cnt_t sat_inc(input cnt_t v);
      return (&v) ? v : v + cnt_t'(1);
   endfunction

   always_comb begin
      start_evt = '0;
      done_evt  = '0;
      count_evt = '0;
      err_evt   = '0;
      to_evt    = '0;
      busy_vec  = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         state_d[c] = state_q[c];
         case (state_q[c])
            S_IDLE: begin
               if (bus.START_in[c]) begin
                  state_d[c]   = S_RUN;
                  start_evt[c] = 1'b1;
               end
            end
            S_RUN: begin
               busy_vec[c] = 1'b1;
               if (bus.DONE_in[c]) begin
                  state_d[c]  = S_IDLE;
                  done_evt[c] = 1'b1;
               end else begin
                  count_evt[c] = 1'b1;
                  err_evt[c]   = bus.START_in[c];
                  if ((bus.TIMEOUT_in != '0) && (run_cnt[c] == bus.TIMEOUT_in)) begin
                     state_d[c] = S_HALT;
                     to_evt[c]  = 1'b1;
                  end
               end
            end
            S_HALT: begin
               if (bus.DONE_in[c]) state_d[c] = S_IDLE;
            end
            default: state_d[c] = S_IDLE;
         endcase
         if (bus.CLEAR_in) state_d[c] = S_IDLE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         to_q       <= '0;
         err_q      <= '0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            state_q[c]   <= S_IDLE;
            run_cnt[c]   <= '0;
            last_lat[c]  <= '0;
            job_cnt[c]   <= '0;
            stall_cnt[c] <= '0;
            busy_cnt[c]  <= '0;
`ifdef SA_PERF_MINMAX_EN
            min_lat[c]   <= '1;
            max_lat[c]   <= '0;
`endif
         end
      end else begin
         // The read captures pre-update counters and survives a same-cycle CLEAR.
         rd_valid_q <= bus.RD_EN_in;
         if (bus.RD_EN_in) rd_data_q <= rd_mux;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            state_q[c] <= state_d[c];
            if (bus.CLEAR_in) begin
               run_cnt[c]   <= '0;
               last_lat[c]  <= '0;
               job_cnt[c]   <= '0;
               stall_cnt[c] <= '0;
               busy_cnt[c]  <= '0;
               to_q[c]      <= 1'b0;
               err_q[c]     <= 1'b0;
`ifdef SA_PERF_MINMAX_EN
               min_lat[c]   <= '1;
               max_lat[c]   <= '0;
`endif
            end else begin
               if (start_evt[c]) begin
                  run_cnt[c] <= cnt_t'(1);
               end else if (count_evt[c]) begin
                  run_cnt[c]  <= sat_inc(run_cnt[c]);
                  busy_cnt[c] <= sat_inc(busy_cnt[c]);
                  if (bus.STALL_in[c]) stall_cnt[c] <= sat_inc(stall_cnt[c]);
               end
               if (done_evt[c]) begin
                  last_lat[c] <= run_cnt[c];
                  job_cnt[c]  <= sat_inc(job_cnt[c]);
`ifdef SA_PERF_MINMAX_EN
                  if (run_cnt[c] < min_lat[c]) min_lat[c] <= run_cnt[c];
                  if (run_cnt[c] > max_lat[c]) max_lat[c] <= run_cnt[c];
`endif
               end
               if (err_evt[c]) err_q[c] <= 1'b1;
               if (to_evt[c])  to_q[c]  <= 1'b1;
            end
         end
      end
   end

   assign rd_ch = bus.RD_CH_in;

   // Out-of-range channels match no loop index and fall through to zero.
   always_comb begin
      rd_mux = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (32'(rd_ch) == c) begin
            case (bus.RD_SEL_in)
               3'd0:    rd_mux = last_lat[c];
               3'd1:    rd_mux = job_cnt[c];
               3'd2:    rd_mux = stall_cnt[c];
               3'd3:    rd_mux = busy_cnt[c];
`ifdef SA_PERF_MINMAX_EN
               3'd4:    rd_mux = min_lat[c];
               3'd5:    rd_mux = max_lat[c];
`endif
               default: rd_mux = '0;
            endcase
         end
      end
   end

   assign bus.RD_VALID_out = rd_valid_q;
   assign bus.RD_DATA_out  = rd_data_q;
   assign bus.BUSY_out     = busy_vec;
   assign bus.TIMEOUT_out  = to_q;
   assign bus.ERR_out      = err_q;
endmodule

// File: tb/tb_sa_perf_monitor.sv
// Self-checking bench for sa_perf_monitor: directed scenarios plus randomized traffic
// against a cycle-timestamp reference model.
module tb_sa_perf_monitor;
   localparam int NCH = 4;

   logic CLK;
   logic RST;
   int   n_checks;
   int   n_errors;

   sa_perf_monitor_if #(.NUM_CH(NCH), .NUM_CH_LOG2(3), .CNT_BWIDTH(32)) bus_if ();

   sa_perf_monitor #(.NUM_CH(NCH), .NUM_CH_LOG2(3), .CNT_BWIDTH(32)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus_if.slave)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Reference model: a job is a start timestamp; latency is edge-count difference.
   int unsigned m_cyc;
   bit          m_run  [NCH];
   bit          m_halt [NCH];
   bit          m_to   [NCH];
   bit          m_err  [NCH];
   int unsigned m_start[NCH];
   logic [31:0] m_last [NCH];
   logic [31:0] m_job  [NCH];
   logic [31:0] m_stall[NCH];
   logic [31:0] m_busy [NCH];
   logic [31:0] m_min  [NCH];
   logic [31:0] m_max  [NCH];
   bit          m_rv;
   logic [31:0] m_rd;

`ifdef SA_PERF_MINMAX_EN
   localparam bit MINMAX = 1'b1;
`else
   localparam bit MINMAX = 1'b0;
`endif

   function automatic logic [31:0] model_read(input int ch, input int sel);
      if (ch >= NCH) return 32'd0;
      case (sel)
         0: return m_last[ch];
         1: return m_job[ch];
         2: return m_stall[ch];
         3: return m_busy[ch];
         4: return MINMAX ? m_min[ch] : 32'd0;
         5: return MINMAX ? m_max[ch] : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_zero();
      for (int c = 0; c < NCH; c++) begin
         m_run[c] = 0; m_halt[c] = 0; m_to[c] = 0; m_err[c] = 0; m_start[c] = 0;
         m_last[c] = 0; m_job[c] = 0; m_stall[c] = 0; m_busy[c] = 0;
         m_min[c] = 32'hFFFF_FFFF; m_max[c] = 0;
      end
   endtask

   task automatic model_step();
      logic [31:0] lat;
      m_cyc++;
      if (RST) begin
         m_rv = 0;
         m_rd = 0;
         model_zero();
      end else begin
         m_rv = bus_if.RD_EN_in;
         if (bus_if.RD_EN_in) m_rd = model_read(int'(bus_if.RD_CH_in), int'(bus_if.RD_SEL_in));
         if (bus_if.CLEAR_in) begin
            model_zero();
         end else begin
            for (int c = 0; c < NCH; c++) begin
               if (m_run[c]) begin
                  if (bus_if.DONE_in[c]) begin
                     lat = 32'(m_cyc - m_start[c]);
                     m_last[c] = lat;
                     m_job[c]  = m_job[c] + 1;
                     if (lat < m_min[c]) m_min[c] = lat;
                     if (lat > m_max[c]) m_max[c] = lat;
                     m_run[c] = 0;
                  end else begin
                     m_busy[c] = m_busy[c] + 1;
                     if (bus_if.STALL_in[c]) m_stall[c] = m_stall[c] + 1;
                     if (bus_if.START_in[c]) m_err[c] = 1;
                     if (bus_if.TIMEOUT_in != 0 && 32'(m_cyc - m_start[c]) == bus_if.TIMEOUT_in) begin
                        m_run[c] = 0; m_halt[c] = 1; m_to[c] = 1;
                     end
                  end
               end else if (m_halt[c]) begin
                  if (bus_if.DONE_in[c]) m_halt[c] = 0;
               end else if (bus_if.START_in[c]) begin
                  m_run[c]   = 1;
                  m_start[c] = m_cyc;
               end
            end
         end
      end
   endtask

   // Advance one rising edge, update the model, then settle before sampling.
   task automatic tick();
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic rd(input int ch, input int sel);
      bus_if.RD_EN_in  = 1'b1;
      bus_if.RD_CH_in  = 3'(ch);
      bus_if.RD_SEL_in = 3'(sel);
      tick();
      bus_if.RD_EN_in  = 1'b0;
   endtask

   task automatic do_clear();
      bus_if.CLEAR_in = 1'b1;
      tick();
      bus_if.CLEAR_in = 1'b0;
   endtask

   task automatic run_job(input int ch, input int lat);
      bus_if.START_in[ch] = 1'b1;
      tick();
      bus_if.START_in[ch] = 1'b0;
      repeat (lat - 1) tick();
      bus_if.DONE_in[ch] = 1'b1;
      tick();
      bus_if.DONE_in[ch] = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (bus_if.BUSY_out !== 4'b0 || bus_if.TIMEOUT_out !== 4'b0 || bus_if.ERR_out !== 4'b0) begin
         n_errors++;
         $display("FAIL reset_flags got %b/%b/%b expected 0/0/0", bus_if.BUSY_out, bus_if.TIMEOUT_out, bus_if.ERR_out);
      end
      n_checks++;
      if (bus_if.RD_VALID_out !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_valid got %b expected 0", bus_if.RD_VALID_out);
      end
      RST = 1'b0;
      rd(0, 1);
      n_checks++;
      if (bus_if.RD_VALID_out !== 1'b1 || bus_if.RD_DATA_out !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_job got %b/%0d expected 1/0", bus_if.RD_VALID_out, bus_if.RD_DATA_out);
      end
      rd(2, 4);
      n_checks++;
      if (bus_if.RD_DATA_out !== (MINMAX ? 32'hFFFF_FFFF : 32'd0)) begin
         n_errors++;
         $display("FAIL reset_min got %h expected %h", bus_if.RD_DATA_out, MINMAX ? 32'hFFFF_FFFF : 32'd0);
      end
   endtask

   task automatic test_latency();
      do_clear();
      bus_if.START_in[0] = 1'b1;
      tick();
      bus_if.START_in[0] = 1'b0;
      n_checks++;
      if (bus_if.BUSY_out[0] !== 1'b1) begin
         n_errors++;
         $display("FAIL lat_busy_on got %b expected 1", bus_if.BUSY_out[0]);
      end
      repeat (31) tick();
      bus_if.DONE_in[0] = 1'b1;
      tick();
      bus_if.DONE_in[0] = 1'b0;
      n_checks++;
      if (bus_if.BUSY_out[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL lat_busy_off got %b expected 0", bus_if.BUSY_out[0]);
      end
      rd(0, 0);
      n_checks++;
      if (bus_if.RD_VALID_out !== 1'b1 || bus_if.RD_DATA_out !== 32'd32) begin
         n_errors++;
         $display("FAIL lat_last got %b/%0d expected 1/32", bus_if.RD_VALID_out, bus_if.RD_DATA_out);
      end
      rd(0, 1);
      n_checks++;
      if (bus_if.RD_DATA_out !== 32'd1) begin
         n_errors++;
         $display("FAIL lat_jobs got %0d expected 1", bus_if.RD_DATA_out);
      end
      tick();
      n_checks++;
      if (bus_if.RD_VALID_out !== 1'b0) begin
         n_errors++;
         $display("FAIL lat_valid_drop got %b expected 0", bus_if.RD_VALID_out);
      end
   endtask

   task automatic test_stall();
      do_clear();
      bus_if.START_in[1] = 1'b1;
      tick();
      bus_if.START_in[1] = 1'b0;
      bus_if.STALL_in[1] = 1'b1;
      repeat (5) tick();
      bus_if.STALL_in[1] = 1'b0;
      repeat (14) tick();
      bus_if.DONE_in[1] = 1'b1;
      tick();
      bus_if.DONE_in[1] = 1'b0;
      rd(1, 2);
      n_checks++;
      if (bus_if.RD_DATA_out !== 32'd5) begin
         n_errors++;
         $display("FAIL stall_cnt got %0d expected 5", bus_if.RD_DATA_out);
      end
      rd(1, 3);
      n_checks++;
      if (bus_if.RD_DATA_out !== 32'd19) begin
         n_errors++;
         $display("FAIL stall_busy got %0d expected 19", bus_if.RD_DATA_out);
      end
      rd(1, 0);
      n_checks++;
      if (bus_if.RD_DATA_out !== 32'd20) begin
         n_errors++;
         $display("FAIL stall_last got %0d expected 20", bus_if.RD_DATA_out);
      end
   endtask

   task automatic test_timeout();
      do_clear();
      bus_if.TIMEOUT_in = 32'd8;
      bus_if.START_in[2] = 1'b1;
      tick();
      bus_if.START_in[2] = 1'b0;
      repeat (7) tick();
      n_checks++;
      if (bus_if.TIMEOUT_out[2] !== 1'b0 || bus_if.BUSY_out[2] !== 1'b1) begin
         n_errors++;
         $display("FAIL to_early got %b/%b expected 0/1", bus_if.TIMEOUT_out[2], bus_if.BUSY_out[2]);
      end
      tick();
      n_checks++;
      if (bus_if.TIMEOUT_out[2] !== 1'b1 || bus_if.BUSY_out[2] !== 1'b0) begin
         n_errors++;
         $display("FAIL to_fire got %b/%b expected 1/0", bus_if.TIMEOUT_out[2], bus_if.BUSY_out[2]);
      end
      repeat (3) tick();
      bus_if.DONE_in[2] = 1'b1;
      tick();
      bus_if.DONE_in[2] = 1'b0;
      rd(2, 1);
      n_checks++;
      if (bus_if.RD_DATA_out !== 32'd0) begin
         n_errors++;
         $display("FAIL to_jobs got %0d expected 0", bus_if.RD_DATA_out);
      end
      rd(2, 0);
      n_checks++;
      if (bus_if.RD_DATA_out !== 32'd0 || bus_if.TIMEOUT_out[2] !== 1'b1) begin
         n_errors++;
         $display("FAIL to_last_sticky got %0d/%b expected 0/1", bus_if.RD_DATA_out, bus_if.TIMEOUT_out[2]);
      end
      do_clear();
      n_checks++;
      if (bus_if.TIMEOUT_out[2] !== 1'b0) begin
         n_errors++;
         $display("FAIL to_clear got %b expected 0", bus_if.TIMEOUT_out[2]);
      end
      bus_if.TIMEOUT_in = 32'd0;
   endtask

   task automatic test_minmax();
      do_clear();
      run_job(3, 7);
      run_job(3, 3);
      run_job(3, 12);
      rd(3, 4);
      n_checks++;
      if (bus_if.RD_DATA_out !== (MINMAX ? 32'd3 : 32'd0)) begin
         n_errors++;
         $display("FAIL mm_min got %0d expected %0d", bus_if.RD_DATA_out, MINMAX ? 3 : 0);
      end
      rd(3, 5);
      n_checks++;
      if (bus_if.RD_DATA_out !== (MINMAX ? 32'd12 : 32'd0)) begin
         n_errors++;
         $display("FAIL mm_max got %0d expected %0d", bus_if.RD_DATA_out, MINMAX ? 12 : 0);
      end
      rd(3, 1);
      n_checks++;
      if (bus_if.RD_DATA_out !== 32'd3) begin
         n_errors++;
         $display("FAIL mm_jobs got %0d expected 3", bus_if.RD_DATA_out);
      end
      rd(3, 6);
      n_checks++;
      if (bus_if.RD_DATA_out !== 32'd0) begin
         n_errors++;
         $display("FAIL mm_sel6 got %0d expected 0", bus_if.RD_DATA_out);
      end
   endtask

   task automatic test_rst_midrun();
      do_clear();
      run_job(0, 4);
      bus_if.START_in[0] = 1'b1;
      tick();
      bus_if.START_in[0] = 1'b0;
      repeat (14) tick();
      RST = 1'b1;
      bus_if.CLEAR_in = 1'b1;
      tick();
      RST = 1'b0;
      bus_if.CLEAR_in = 1'b0;
      n_checks++;
      if (bus_if.BUSY_out !== 4'b0) begin
         n_errors++;
         $display("FAIL rst_busy got %b expected 0000", bus_if.BUSY_out);
      end
      for (int s = 0; s < 4; s++) begin
         rd(0, s);
         n_checks++;
         if (bus_if.RD_DATA_out !== 32'd0) begin
            n_errors++;
            $display("FAIL rst_sel%0d got %0d expected 0", s, bus_if.RD_DATA_out);
         end
      end
      run_job(0, 9);
      rd(0, 0);
      n_checks++;
      if (bus_if.RD_DATA_out !== 32'd9) begin
         n_errors++;
         $display("FAIL rst_fresh_lat got %0d expected 9", bus_if.RD_DATA_out);
      end
      rd(0, 1);
      n_checks++;
      if (bus_if.RD_DATA_out !== 32'd1) begin
         n_errors++;
         $display("FAIL rst_fresh_jobs got %0d expected 1", bus_if.RD_DATA_out);
      end
   endtask

   task automatic test_start_done_err();
      do_clear();
      bus_if.START_in[1] = 1'b1;
      bus_if.DONE_in[1]  = 1'b1;
      tick();
      bus_if.START_in[1] = 1'b0;
      bus_if.DONE_in[1]  = 1'b0;
      n_checks++;
      if (bus_if.BUSY_out[1] !== 1'b1 || bus_if.ERR_out[1] !== 1'b0) begin
         n_errors++;
         $display("FAIL sd_enter got %b/%b expected 1/0", bus_if.BUSY_out[1], bus_if.ERR_out[1]);
      end
      repeat (2) tick();
      bus_if.START_in[1] = 1'b1;
      tick();
      n_checks++;
      if (bus_if.ERR_out[1] !== 1'b1 || bus_if.BUSY_out[1] !== 1'b1) begin
         n_errors++;
         $display("FAIL sd_err got %b/%b expected 1/1", bus_if.ERR_out[1], bus_if.BUSY_out[1]);
      end
      bus_if.DONE_in[1] = 1'b1;
      tick();
      bus_if.START_in[1] = 1'b0;
      bus_if.DONE_in[1]  = 1'b0;
      n_checks++;
      if (bus_if.BUSY_out[1] !== 1'b0) begin
         n_errors++;
         $display("FAIL sd_no_restart got %b expected 0", bus_if.BUSY_out[1]);
      end
      rd(1, 0);
      n_checks++;
      if (bus_if.RD_DATA_out !== 32'd4) begin
         n_errors++;
         $display("FAIL sd_lat got %0d expected 4", bus_if.RD_DATA_out);
      end
      rd(5, 1);
      n_checks++;
      if (bus_if.RD_VALID_out !== 1'b1 || bus_if.RD_DATA_out !== 32'd0) begin
         n_errors++;
         $display("FAIL sd_bad_ch got %b/%0d expected 1/0", bus_if.RD_VALID_out, bus_if.RD_DATA_out);
      end
   endtask

   task automatic test_clear_priority();
      do_clear();
      run_job(0, 5);
      bus_if.CLEAR_in    = 1'b1;
      bus_if.START_in[2] = 1'b1;
      rd(0, 0);
      bus_if.CLEAR_in    = 1'b0;
      bus_if.START_in[2] = 1'b0;
      n_checks++;
      if (bus_if.RD_VALID_out !== 1'b1 || bus_if.RD_DATA_out !== 32'd5) begin
         n_errors++;
         $display("FAIL clr_pending_rd got %b/%0d expected 1/5", bus_if.RD_VALID_out, bus_if.RD_DATA_out);
      end
      n_checks++;
      if (bus_if.BUSY_out[2] !== 1'b0) begin
         n_errors++;
         $display("FAIL clr_over_start got %b expected 0", bus_if.BUSY_out[2]);
      end
      rd(0, 0);
      n_checks++;
      if (bus_if.RD_DATA_out !== 32'd0) begin
         n_errors++;
         $display("FAIL clr_zeroed got %0d expected 0", bus_if.RD_DATA_out);
      end
   endtask

   task automatic test_random();
      logic [3:0] exp_busy, exp_to, exp_err;
      do_clear();
      for (int i = 0; i < 800; i++) begin
         for (int c = 0; c < NCH; c++) begin
            bus_if.START_in[c] = ($urandom_range(0, 7) == 0);
            bus_if.DONE_in[c]  = ($urandom_range(0, 9) == 0);
            bus_if.STALL_in[c] = ($urandom_range(0, 2) == 0);
         end
         bus_if.CLEAR_in  = ($urandom_range(0, 99) == 0);
         RST              = ($urandom_range(0, 299) == 0);
         bus_if.RD_EN_in  = ($urandom_range(0, 1) == 1);
         bus_if.RD_CH_in  = 3'($urandom_range(0, 7));
         bus_if.RD_SEL_in = 3'($urandom_range(0, 7));
         tick();
         for (int c = 0; c < NCH; c++) begin
            exp_busy[c] = m_run[c];
            exp_to[c]   = m_to[c];
            exp_err[c]  = m_err[c];
         end
         n_checks++;
         if (bus_if.BUSY_out !== exp_busy) begin
            n_errors++;
            $display("FAIL rand_busy cyc %0d got %b expected %b", i, bus_if.BUSY_out, exp_busy);
         end
         n_checks++;
         if (bus_if.TIMEOUT_out !== exp_to || bus_if.ERR_out !== exp_err) begin
            n_errors++;
            $display("FAIL rand_flags cyc %0d got %b/%b expected %b/%b", i, bus_if.TIMEOUT_out, bus_if.ERR_out, exp_to, exp_err);
         end
         n_checks++;
         if (bus_if.RD_VALID_out !== m_rv) begin
            n_errors++;
            $display("FAIL rand_valid cyc %0d got %b expected %b", i, bus_if.RD_VALID_out, m_rv);
         end
         if (m_rv) begin
            n_checks++;
            if (bus_if.RD_DATA_out !== m_rd) begin
               n_errors++;
               $display("FAIL rand_data cyc %0d got %0d expected %0d", i, bus_if.RD_DATA_out, m_rd);
            end
         end
      end
      bus_if.START_in = '0;
      bus_if.DONE_in  = '0;
      bus_if.STALL_in = '0;
      bus_if.CLEAR_in = 1'b0;
      bus_if.RD_EN_in = 1'b0;
      RST             = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      m_cyc    = 0;
      m_rv     = 0;
      m_rd     = 0;
      model_zero();
      RST               = 1'b1;
      bus_if.CLEAR_in   = 1'b0;
      bus_if.START_in   = '0;
      bus_if.DONE_in    = '0;
      bus_if.STALL_in   = '0;
      bus_if.TIMEOUT_in = '0;
      bus_if.RD_EN_in   = 1'b0;
      bus_if.RD_CH_in   = '0;
      bus_if.RD_SEL_in  = '0;
      test_reset();
      test_latency();
      test_stall();
      test_timeout();
      test_minmax();
      test_rst_midrun();
      test_start_done_err();
      test_clear_priority();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/sa_perf_monitor.md
SA_PERF_MONITOR -- requirements
Module: sa_perf_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent monitored channels.
REQ-002 SHALL have parameter NUM_CH_LOG2, default 2: width of the channel select.
REQ-003 SHALL have parameter CNT_BWIDTH, default 32: width of every counter, the timeout threshold and RD_DATA_out.
REQ-004 SHALL have port CLK, input, 1: single clock; every register samples on the rising edge.
REQ-005 SHALL have port RST, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port CLEAR_in, input, 1: synchronous clear of all channels.
REQ-007 SHALL have ports START_in / DONE_in / STALL_in, input, NUM_CH each: per-channel job start pulse, job done pulse, stall level.
REQ-008 SHALL have port TIMEOUT_in, input, CNT_BWIDTH: run-length limit; 0 disables the timeout.
REQ-009 SHALL have ports RD_EN_in (input, 1), RD_CH_in (input, NUM_CH_LOG2) and RD_SEL_in (input, 3): read request, channel and counter select.
REQ-010 SHALL have ports RD_VALID_out (output, 1) and RD_DATA_out (output, CNT_BWIDTH): read response.
REQ-011 SHALL have ports BUSY_out (output, NUM_CH): channel in RUN; TIMEOUT_out (output, NUM_CH): sticky timeout flag; ERR_out (output, NUM_CH): sticky START-while-RUN flag.

Function
REQ-012 Each channel SHALL run its own FSM with states IDLE, RUN and HALT.
REQ-013 IDLE: START_in high -> RUN, run_cnt loads 1; DONE_in alone is ignored; START and DONE in the same cycle -> START wins, DONE ignored.
REQ-014 RUN, DONE_in high -> IDLE, LAST_LAT <= run_cnt, JOB_CNT += 1; a START_in in the same cycle is ignored (no back-to-back restart).
REQ-015 RUN without DONE: run_cnt += 1; BUSY_CNT += 1; STALL_CNT += 1 when STALL_in is high.
REQ-016 RUN: START without DONE -> ERR_out sticky set, state unchanged.
REQ-017 Latency definition: START sampled at edge t and DONE sampled at edge t+L SHALL give LAST_LAT = L.
REQ-018 RUN with TIMEOUT_in != 0, run_cnt == TIMEOUT_in and DONE low -> HALT; TIMEOUT_out set sticky.
REQ-019 HALT: counters frozen; DONE_in -> IDLE without updating LAST_LAT or JOB_CNT.
REQ-020 All counters SHALL saturate at all-ones and never wrap.
REQ-021 Read timing: RD_EN_in at edge t -> RD_VALID_out = 1 and RD_DATA_out registered at t+1.
REQ-022 Read data SHALL be the pre-update counter value when the counter also updates at edge t.
REQ-023 RD_SEL_in mapping: 0 LAST_LAT, 1 JOB_CNT, 2 STALL_CNT, 3 BUSY_CNT, 4 MIN_LAT, 5 MAX_LAT; codes 6-7 read 0.
REQ-024 RD_CH_in >= NUM_CH SHALL read 0 with RD_VALID_out = 1.
REQ-025 RD_VALID_out SHALL be 0 in every cycle following RD_EN_in = 0.
REQ-026 CLEAR_in SHALL zero all counters, force every FSM to IDLE and clear TIMEOUT_out and ERR_out.
REQ-027 CLEAR_in SHALL take priority over START_in and DONE_in in the same cycle.
REQ-028 CLEAR_in SHALL NOT cancel a read response already pending.

Reset
REQ-029 RST SHALL force FSMs to IDLE, zero all counters and outputs and set MIN_LAT to all-ones.
REQ-030 RST mid-run SHALL discard the run in progress; RST has priority over CLEAR_in and all other inputs.

Configuration
REQ-031 Macro SA_PERF_MINMAX_EN defined: per-channel MIN_LAT and MAX_LAT registers are built and updated on every DONE that ends a RUN.
REQ-032 With SA_PERF_MINMAX_EN, CLEAR_in and RST set MIN_LAT to all-ones and MAX_LAT to 0.
REQ-033 Macro SA_PERF_MINMAX_EN undefined: no min/max registers; RD_SEL_in 4 and 5 read 0.

Verification (NUM_CH=4, CNT_BWIDTH=32)
REQ-034 ch0 START at cycle 10, DONE at cycle 42 -> sel0 reads 32, sel1 reads 1, BUSY_out[0] = 0 from cycle 43.
REQ-035 ch1 START, then STALL high for 5 of 20 run cycles, DONE -> sel2 reads 5, sel3 reads 19, sel0 reads 20.
REQ-036 TIMEOUT_in = 8, ch2 START with no DONE -> TIMEOUT_out[2] = 1 eight cycles after START; a later DONE leaves sel1 = 0; CLEAR_in clears the flag.
REQ-037 ch3 jobs of latency 7, 3 and 12 -> MIN_LAT 3 and MAX_LAT 12 with SA_PERF_MINMAX_EN; both read 0 without it.
REQ-038 RST asserted mid-run on ch0 at run_cnt = 15 -> all reads 0, BUSY_out = 0; next START/DONE gives the correct fresh latency.
REQ-039 START with DONE in IDLE on ch1 -> RUN entered; START during RUN -> ERR_out[1] = 1; read with RD_CH_in = 5 (NUM_CH=4, RD_CH width widened for this test) returns 0 one cycle later.
